// File: rtl/gate_logic_pipe.sv
// -----------------------------------------------------------------------------
// gate_logic_pipe
//
// Pipelined bitwise logic unit. One opcode-selected WIDTH-bit operation is
// applied to (in_a, in_b). The result, its zero flag and the opcode then travel
// through STAGES register stages under valid/ready flow control. The ready
// chain is purely combinational, so there is no skid buffer. Bubbles collapse
// even while the output is stalled.
//
// Parameters:
//   WIDTH   operand/result width in bits (>= 1)
//   STAGES  pipeline register stages (1..4); latency in cycles with no stall
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands/op valid this cycle
//   in_ready   block can accept this cycle
//   in_a/in_b  operands
//   in_op      operation select:
//                000 AND, 001 OR, 010 NOT a, 011 NAND,
//                100 NOR, 101 XOR, 110 XNOR, 111 PASS a
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_y      result (holds its last value while out_valid = 0)
//   out_zero   1 when out_y == 0
//   out_op     opcode that produced out_y
//
// Optional feature (macro GATE_LOGIC_PIPE_STATS_EN):
//   stat_count 16-bit saturating count of output transfers; cleared by rst.
// -----------------------------------------------------------------------------
module gate_logic_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic [2:0]       out_op
`ifdef GATE_LOGIC_PIPE_STATS_EN
    ,
    output logic [15:0]      stat_count
`endif
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOTA = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("gate_logic_pipe: STAGES must be in 1..4");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Combinational logic function
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] res_y;
    logic             res_zero;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the block leaves it unassigned (which would infer a latch).
        res_y = '0;
        case (in_op)
            OP_AND:  res_y = in_a & in_b;
            OP_OR:   res_y = in_a | in_b;
            OP_NOTA: res_y = ~in_a;
            OP_NAND: res_y = ~(in_a & in_b);
            OP_NOR:  res_y = ~(in_a | in_b);
            OP_XOR:  res_y = in_a ^ in_b;
            OP_XNOR: res_y = ~(in_a ^ in_b);
            OP_PASS: res_y = in_a;
            default: res_y = '0;
        endcase
        res_zero = ~|res_y;
    end

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] zero_q,  zero_d;
    logic [WIDTH-1:0]  y_q  [STAGES];
    logic [WIDTH-1:0]  y_d  [STAGES];
    logic [2:0]        op_q [STAGES];
    logic [2:0]        op_d [STAGES];
    logic [STAGES-1:0] adv;

    // Stage k advances when it, or any later stage, is empty, or when the
    // consumer takes the last item. The accumulator runs from the output side
    // back towards the input. This avoids a vector that reads its own bits.
    always_comb begin
        logic acc;
        adv = '0;
        acc = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc    = acc | ~valid_q[k];
            adv[k] = acc;
        end
    end

    // adv[0] already contains ~valid_q[0].
    assign in_ready = adv[0];

    // Payload registers load only when a valid item arrives. As a result, the
    // outputs keep their last value through bubbles.
    always_comb begin
        valid_d = valid_q;
        zero_d  = zero_q;
        y_d     = y_q;
        op_d    = op_q;
        if (adv[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                y_d[0]    = res_y;
                zero_d[0] = res_zero;
                op_d[0]   = in_op;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    y_d[k]    = y_q[k-1];
                    zero_d[k] = zero_q[k-1];
                    op_d[k]   = op_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload registers are reset along with the valid bits.
            // This makes the outputs read all-zero right after reset instead
            // of showing stale data.
            valid_q <= '0;
            zero_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                y_q[k]  <= '0;
                op_q[k] <= '0;
            end
        end else begin
            // NOTE: state uses non-blocking assignments, so every stage samples
            // the pre-edge value of its neighbour, which gives a true shift.
            valid_q <= valid_d;
            zero_q  <= zero_d;
            y_q     <= y_d;
            op_q    <= op_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_y     = y_q[STAGES-1];
    assign out_zero  = zero_q[STAGES-1];
    assign out_op    = op_q[STAGES-1];

`ifdef GATE_LOGIC_PIPE_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating output-transfer counter
    // -------------------------------------------------------------------------
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (out_valid && out_ready && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_gate_logic_pipe.sv
// -----------------------------------------------------------------------------
// tb_gate_logic_pipe
//
// Bench for gate_logic_pipe. It uses two instances:
//   u_dut8  : WIDTH=8,  STAGES=2 for directed vectors with hand-computed results
//   u_dut32 : WIDTH=32, STAGES=4 for random valid/ready traffic checked
//             against a queue-based reference model
// If GATE_LOGIC_PIPE_STATS_EN is defined, the saturating counter on u_dut8 is
// also exercised.
// -----------------------------------------------------------------------------
module tb_gate_logic_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit, 2-stage instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_zero8;
    logic [7:0] in_a8, in_b8, out_y8;
    logic [2:0] in_op8, out_op8;

    // 32-bit, 4-stage instance
    logic        in_valid32, in_ready32, out_valid32, out_ready32, out_zero32;
    logic [31:0] in_a32, in_b32, out_y32;
    logic [2:0]  in_op32, out_op32;

`ifdef GATE_LOGIC_PIPE_STATS_EN
    logic [15:0] stat8, stat32;
`endif

    gate_logic_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_a      (in_a8),
        .in_b      (in_b8),
        .in_op     (in_op8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_y     (out_y8),
        .out_zero  (out_zero8),
        .out_op    (out_op8)
`ifdef GATE_LOGIC_PIPE_STATS_EN
        ,
        .stat_count(stat8)
`endif
    );

    gate_logic_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_a      (in_a32),
        .in_b      (in_b32),
        .in_op     (in_op32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_y     (out_y32),
        .out_zero  (out_zero32),
        .out_op    (out_op32)
`ifdef GATE_LOGIC_PIPE_STATS_EN
        ,
        .stat_count(stat32)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return ~a;
            3'b011:  return ~(a & b);
            3'b100:  return ~(a | b);
            3'b101:  return a ^ b;
            3'b110:  return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [31:0] y;
        logic        zero;
        logic [2:0]  op;
    } item_t;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_t1 [8];
        item_t      q[$];
        item_t      it;
        int         occ, sent, cycles;

        exp_t1 = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0};

        rst = 1'b1;
        in_valid8 = 0; in_a8 = '0; in_b8 = '0; in_op8 = '0; out_ready8 = 1;
        in_valid32 = 0; in_a32 = '0; in_b32 = '0; in_op32 = '0; out_ready32 = 1;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // ---- reset state
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_out_y",     32'(out_y8),     32'd0);
        check("rst_out_zero",  32'(out_zero8),  32'd0);
        check("rst_out_op",    32'(out_op8),    32'd0);
        check("rst_in_ready",  32'(in_ready8),  32'd1);
`ifdef GATE_LOGIC_PIPE_STATS_EN
        check("rst_stat", 32'(stat8), 32'd0);
`endif

        // ---- all opcodes back-to-back, F0/3C; latency 2, then one result per cycle
        in_a8 = 8'hF0; in_b8 = 8'h3C; out_ready8 = 1;
        for (int i = 0; i < 10; i++) begin
            in_valid8 = (i < 8);
            in_op8    = 3'(i);
            #1;
            if (i < 8) check("ops_in_ready", 32'(in_ready8), 32'd1);
            tick();
            check("ops_out_valid", 32'(out_valid8), (i >= 1 && i <= 8) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= 8) begin
                check("ops_out_y",  32'(out_y8),  32'(exp_t1[i-1]));
                check("ops_out_op", 32'(out_op8), 32'(i - 1));
            end
        end
        in_valid8 = 0;
`ifdef GATE_LOGIC_PIPE_STATS_EN
        check("stat_after_ops", 32'(stat8), 32'd8);
`endif

        // ---- zero flag: AA&55 = 00 (zero), AA|55 = FF (not zero)
        in_a8 = 8'hAA; in_b8 = 8'h55; in_valid8 = 1; in_op8 = 3'b000;
        tick();
        in_op8 = 3'b001;
        tick();
        in_valid8 = 0;
        check("zf_and_valid", 32'(out_valid8), 32'd1);
        check("zf_and_y",     32'(out_y8),     32'h00);
        check("zf_and_zero",  32'(out_zero8),  32'd1);
        tick();
        check("zf_or_y",      32'(out_y8),     32'hFF);
        check("zf_or_zero",   32'(out_zero8),  32'd0);
        tick();
        check("zf_drained",   32'(out_valid8), 32'd0);

        // ---- backpressure: XOR with 0F on 11, 22, 33 -> 1E, 2D, 3C
        out_ready8 = 0; in_op8 = 3'b101; in_b8 = 8'h0F;
        in_valid8 = 1; in_a8 = 8'h11;
        #1;
        check("bp_rdy0", 32'(in_ready8), 32'd1);
        tick();
        in_a8 = 8'h22;
        #1;
        check("bp_rdy1", 32'(in_ready8), 32'd1);
        tick();
        in_a8 = 8'h33;
        #1;
        check("bp_rdy_full", 32'(in_ready8), 32'd0);
        check("bp_out_valid", 32'(out_valid8), 32'd1);
        check("bp_out_y", 32'(out_y8), 32'h1E);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_y",     32'(out_y8),     32'h1E);
            check("bp_hold_valid", 32'(out_valid8), 32'd1);
            check("bp_hold_rdy",   32'(in_ready8),  32'd0);
        end
        out_ready8 = 1;
        #1;
        check("bp_rdy_release", 32'(in_ready8), 32'd1);
        tick();
        in_valid8 = 0;
        check("bp_item1_valid", 32'(out_valid8), 32'd1);
        check("bp_item1_y",     32'(out_y8),     32'h2D);
        tick();
        check("bp_item2_valid", 32'(out_valid8), 32'd1);
        check("bp_item2_y",     32'(out_y8),     32'h3C);
        check("bp_item2_op",    32'(out_op8),    32'd5);
        tick();
        check("bp_no_dup", 32'(out_valid8), 32'd0);

        // ---- reset with 2 items in flight; a coincident input is discarded
        out_ready8 = 0; in_op8 = 3'b111; in_valid8 = 1; in_a8 = 8'h01;
        tick();
        in_a8 = 8'h02;
        tick();
        in_a8 = 8'h03; rst = 1;
        tick();
        rst = 0; in_valid8 = 0;
        #1;
        check("mrst_out_valid", 32'(out_valid8), 32'd0);
        check("mrst_out_y",     32'(out_y8),     32'd0);
        check("mrst_out_zero",  32'(out_zero8),  32'd0);
        check("mrst_out_op",    32'(out_op8),    32'd0);
        check("mrst_in_ready",  32'(in_ready8),  32'd1);
`ifdef GATE_LOGIC_PIPE_STATS_EN
        check("mrst_stat", 32'(stat8), 32'd0);
`endif
        out_ready8 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mrst_no_stale", 32'(out_valid8), 32'd0);
        end

        // ---- random traffic on the 32-bit, 4-stage instance
        occ = 0; sent = 0; cycles = 0;
        while ((sent < 1000 || q.size() > 0) && cycles < 20000) begin
            in_valid32  = (sent < 1000) && ($urandom_range(0, 9) < 7);
            in_a32      = $urandom;
            in_b32      = $urandom;
            in_op32     = 3'($urandom_range(0, 7));
            out_ready32 = (sent >= 1000) || ($urandom_range(0, 9) < 6);
            #1;
            check("rnd_in_ready", 32'(in_ready32), ((occ < 4) || out_ready32) ? 32'd1 : 32'd0);
            if (out_valid32 && out_ready32) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", 32'(out_valid32), 32'd0);
                end else begin
                    it = q.pop_front();
                    check("rnd_y",    out_y32,           it.y);
                    check("rnd_zero", 32'(out_zero32),   32'(it.zero));
                    check("rnd_op",   32'(out_op32),     32'(it.op));
                    occ--;
                end
            end
            if (in_valid32 && in_ready32) begin
                it.y    = ref_op(in_op32, in_a32, in_b32);
                it.zero = (it.y == 32'd0);
                it.op   = in_op32;
                q.push_back(it);
                sent++;
                occ++;
            end
            tick();
            cycles++;
        end
        in_valid32 = 0;
        check("rnd_budget", 32'(cycles < 20000), 32'd1);
        check("rnd_sent",   32'(sent),           32'd1000);
        check("rnd_drained", 32'(q.size()),      32'd0);
        tick();
        check("rnd_idle_valid", 32'(out_valid32), 32'd0);

`ifdef GATE_LOGIC_PIPE_STATS_EN
        // ---- saturation of the output-transfer counter
        rst = 1;
        tick();
        rst = 0;
        in_valid8 = 1; out_ready8 = 1; in_op8 = 3'b000;
        for (int i = 0; i < 65540; i++) tick();
        in_valid8 = 0;
        for (int i = 0; i < 3; i++) tick();
        check("stat_sat", 32'(stat8), 32'hFFFF);
        in_valid8 = 1;
        for (int i = 0; i < 4; i++) tick();
        in_valid8 = 0;
        check("stat_sat_hold", 32'(stat8), 32'hFFFF);
        rst = 1;
        tick();
        rst = 0;
        check("stat_clear", 32'(stat8), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gate_logic_pipe.md
Name: gate_logic_pipe

Overview:
Parametrised, pipelined bitwise logic unit. It is the sequential successor to the team's standalone AND/OR/NOT/NAND gate modules. One opcode-selected WIDTH-bit operation is applied to (a, b), and the result passes through STAGES register stages under valid/ready flow control. The block sits between datapath producers and consumers that need registered, back-pressurable logic results and a zero flag.

Parameters:
WIDTH, 32, operand/result width in bits (>=1)
STAGES, 2, pipeline register stages (1..4); latency in cycles with no stall

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands/op valid this cycle
in_ready  output  1  block can accept this cycle
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_op  input  3  operation select
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_y  output  WIDTH  result
out_zero  output  1  1 when out_y == 0
out_op  output  3  opcode that produced out_y

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Sampled only on the rising edge of clk.
- Opcodes (y = f(a,b)):
  - 000 AND
  - 001 OR
  - 010 NOT a (b ignored)
  - 011 NAND
  - 100 NOR
  - 101 XOR
  - 110 XNOR
  - 111 PASS a
- All operations are full WIDTH and bitwise. No carries, no width change.
- Result and zero flag are computed combinationally from in_a, in_b and in_op. They are captured into stage 0 on input transfer (in_valid & in_ready).
- Stages 1..STAGES-1 carry {valid, y, zero, op}. The last stage drives the out_* ports.
- Stage k advances when it is empty, or when stage k+1 advances. For the last stage, "stage k+1 advances" means out_ready.
- in_ready = ~valid[0] | advance[0]. This is a combinational path from out_ready through the ready chain. No skid buffer is used.
- Throughput: 1 transfer/cycle while out_ready=1.
- Latency: result appears on out_valid exactly STAGES cycles after the input transfer edge, provided there is no stall.
- Stall (out_ready=0 with out_valid=1):
  - out_y, out_zero and out_op hold stable.
  - Bubbles upstream still collapse: an empty stage fills even while later stages are stalled.
  - The pipeline accepts up to STAGES items in total, then in_ready=0.
- out_* data is don't-care when out_valid=0. The implementation holds the last value.
- Transfer occurs only on valid & ready. No item is ever duplicated or dropped.
- Reset (including mid-operation):
  - Every valid bit returns to 0 and all in-flight items are discarded.
  - out_y=0, out_zero=0, out_op=0 and out_valid=0 on the cycle after rst is sampled high.
  - in_ready=1 while rst is low and the pipe is empty.
  - An input transfer coinciding with rst=1 is discarded.
- Simultaneous events:
  - Last stage emits and stage 0 captures in the same cycle: both happen.
  - When the pipe is full and out_ready=1, in_ready=1 and occupancy stays constant.
- STAGES outside 1..4 is a configuration error. Elaboration fails via a generate-time check.

Optional Feature:
GATE_LOGIC_PIPE_STATS_EN
- Defined: adds output port stat_count (16 bits).
  - Increments by 1 on each output transfer (out_valid & out_ready).
  - Saturates at 16'hFFFF.
  - Resets to 0 on rst.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1; send a=8'hF0, b=8'h3C with op 000..111 back-to-back. Required: results 30, FC, 0F, CF, 03, CC, 33, F0 in order. First result appears 2 cycles after the first accept, then one per cycle. out_op matches each result.
- a=8'hAA, b=8'h55, op=000. Required: out_y=00, out_zero=1. Same operands with op=001: out_y=FF, out_zero=0.
- Backpressure: out_ready=0 and stream 3 items with op=101. Required: in_ready drops after 2 accepts, and out_y holds stable for 5 cycles. Then raise out_ready: all items emerge in order, with no loss or duplication.
- Assert rst for 1 cycle with 2 items in flight. Required: next cycle out_valid=0, out_y=0 and in_ready=1. No stale item emerges afterwards.
- Random valid/ready toggling over 1000 items, WIDTH=32, STAGES=4. Required: the scoreboard matches the reference model exactly, and in_ready never asserts while the pipe is full unless out_ready=1.
- With GATE_LOGIC_PIPE_STATS_EN defined: force the counter near FFFF via 65540 transfers. Required: stat_count=FFFF and it stays there. rst clears it to 0.
